mem_arbiter: RTL and testbench
==============================

Name:
mem_arbiter

Overview:
- Sequences the single shared RAM port between the instruction-fetch path (imem) and the load/store path (dmem) of the MIPS datapath.
- Sits between the datapath and the RAM model. Produces the iwait/dwait hold signals from which the datapath derives ihit/dhit.
- Owns arbitration, access hold-until-done, bounded retry on RAM error, and halt gating of fetches.

Parameters:
- MAX_RETRY, 3: consecutive RAM ERROR responses tolerated on one access before err is flagged and the access is abandoned.

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous, active-low reset
- halt  in  1  datapath halted; blocks new instruction grants
- iREN  in  1  instruction read request
- iaddr  in  32  instruction address
- iload  out  32  instruction data, valid when iwait=0
- iwait  out  1  1 = instruction request not yet satisfied
- dREN  in  1  data read request
- dWEN  in  1  data write request (dREN&dWEN both high is illegal; treat as read)
- daddr  in  32  data address
- dstore  in  32  write data
- dload  out  32  read data, valid when dwait=0
- dwait  out  1  1 = data request not yet satisfied
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  FREE/BUSY/ACCESS/ERROR
- err  out  1  sticky: retry limit exceeded; cleared only by reset

Behaviour:
- States: IDLE, IGRANT, DGRANT. Reset → IDLE, retry count 0, err=0, last_owner=INSTR.
- All RAM outputs are decoded from the registered state; there is no combinational request→RAM path. Arbitration latency is 1 cycle.
- IDLE drives ramREN=ramWEN=0 and ramaddr=ramstore=0.
- IDLE arbitration:
  - dREN|dWEN alone → DGRANT.
  - iREN&~halt alone → IGRANT.
  - Both pending: data wins unless last_owner=DATA, in which case instruction wins. This makes alternation fair.
- IGRANT drives ramREN=1, ramaddr=iaddr.
- DGRANT drives ramREN=dREN, ramWEN=dWEN&~dREN, ramaddr=daddr, ramstore=dstore.
- Completion occurs when ramstate=ACCESS while granted:
  - The owner's wait goes 0 combinationally in the same cycle; iload/dload = ramload.
  - Next state is IDLE; last_owner updates; retry count clears.
- iwait/dwait are 1 whenever the corresponding request is asserted and not completing this cycle. They are 0 when no request is asserted.
- ramstate=ERROR while granted:
  - Increment retry count and stay in the grant, re-issuing next cycle.
  - When count reaches MAX_RETRY: set err, return to IDLE, and pulse the owner's wait low for one cycle so the datapath can progress; load data = 0.
- Owner drops its request while granted (mid-access): return to IDLE next cycle. No completion is signalled and retry count clears.
- halt during IGRANT lets the in-flight fetch finish. No new IGRANT is issued while halt=1; data requests are still served.
- nRST low mid-access forces IDLE immediately (async). RAM strobes drop the same instant.

Decomposition:
- Shared package mem_arb_pkg: ramstate_t enum (FREE=0, BUSY=1, ACCESS=2, ERROR=3), arb_state_t (IDLE/IGRANT/DGRANT), owner_t.
- Sub-module arb_retry_counter: saturating counter with clear/inc/limit output, width $clog2(MAX_RETRY+1).

Test Plan:
- iREN=1, iaddr=0x40, ramstate BUSY 2 cycles then ACCESS with ramload=0x2108000A → ramREN=1/ramaddr=0x40 from cycle 1; iwait=0 and iload=0x2108000A only on the ACCESS cycle.
- dWEN=1 (daddr=0x100, dstore=0xDEADBEEF) and iREN=1 together from IDLE:
  - DGRANT first with ramWEN=1.
  - After ACCESS, IGRANT next. dwait falls before iwait.
- Back-to-back dREN and iREN held high for 6 accesses → grants alternate D,I,D,I,D,I.
- MAX_RETRY=3, data read with ramstate=ERROR 3 times → err=1 after the third; dwait low for 1 cycle; state IDLE.
- halt=1 with iREN=1 → no ramREN for 10 cycles. A dREN raised meanwhile is served normally.
- Assert nRST low during DGRANT with BUSY → ramREN/ramWEN=0 immediately; after release, state IDLE and err=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the imem/dmem RAM port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IGRANT = 2'd1,
      DGRANT = 2'd2
   } arb_state_t;

   typedef enum logic {
      INSTR = 1'b0,
      DATA  = 1'b1
   } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Datapath and RAM signals seen by the arbiter, bundled as one bus.
interface mem_arbiter_if;
   import mem_arb_pkg::*;

   logic        halt;
   logic        iREN;
   logic [31:0] iaddr;
   logic [31:0] iload;
   logic        iwait;
   logic        dREN;
   logic        dWEN;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic [31:0] dload;
   logic        dwait;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload;
   ramstate_t   ramstate;
   logic        err;

   // datapath + RAM side
   modport master (
      output halt, iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, err
   );

   // arbiter side
   modport slave (
      input  halt, iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, err
   );

endinterface

// File: rtl/arb_retry_counter.sv
// Saturating retry counter; last flags that one more error hits the limit.
module arb_retry_counter #(
   parameter int MAX_RETRY = 3
) (
   input  logic                           CLK,
   input  logic                           nRST,
   input  logic                           clear,
   input  logic                           inc,
   output logic [$clog2(MAX_RETRY+1)-1:0] count,
   output logic                           last
);
   localparam int W = $clog2(MAX_RETRY+1);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (inc && (count != W'(MAX_RETRY)))
         count <= count + W'(1);
   end

   assign last = (count == W'(MAX_RETRY - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Shares one RAM port between instruction fetch and load/store, with
// alternating priority, bounded error retry and halt gating of fetches.
//
//   state  | meaning
//   IDLE   | no owner; RAM strobes low; arbitrate pending requests
//   IGRANT | instruction fetch owns the RAM port until ACCESS/abort/drop
//   DGRANT | load/store owns the RAM port until ACCESS/abort/drop
module mem_arbiter #(
   parameter int MAX_RETRY = 3
) (
   input  logic          CLK,
   input  logic          nRST,
   mem_arbiter_if.slave  bus
);
   import mem_arb_pkg::*;

   localparam int CW = $clog2(MAX_RETRY+1);

   arb_state_t    state, next_state;
   owner_t        last_owner;
   logic          err_r;
   logic [CW-1:0] retry_cnt;
   logic          retry_last;

   logic d_req, i_ok, granted_i, granted_d, own_req;
   logic ram_access, ram_error, done, abort, cnt_inc, cnt_clear;

   assign d_req      = bus.dREN | bus.dWEN;
   assign i_ok       = bus.iREN & ~bus.halt;
   assign granted_i  = (state == IGRANT);
   assign granted_d  = (state == DGRANT);
   assign own_req    = (granted_i & bus.iREN) | (granted_d & d_req);
   assign ram_access = (bus.ramstate == ACCESS);
   assign ram_error  = (bus.ramstate == ERROR);
   assign done       = own_req & ram_access;
   assign abort      = own_req & ram_error & retry_last;
   assign cnt_inc    = own_req & ram_error & ~retry_last;
   // any exit from a grant (done, abort or dropped request) restarts the count
   assign cnt_clear  = (state != IDLE) & (~own_req | done | abort);

   arb_retry_counter #(.MAX_RETRY(MAX_RETRY)) u_retry (
      .CLK   (CLK),
      .nRST  (nRST),
      .clear (cnt_clear),
      .inc   (cnt_inc),
      .count (retry_cnt),
      .last  (retry_last)
   );

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state      <= IDLE;
         last_owner <= INSTR;
         err_r      <= 1'b0;
      end else begin
         state <= next_state;
         if (done)
            last_owner <= granted_i ? INSTR : DATA;
         if (abort)
            err_r <= 1'b1;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (d_req && i_ok)
               next_state = (last_owner == DATA) ? IGRANT : DGRANT;
            else if (d_req)
               next_state = DGRANT;
            else if (i_ok)
               next_state = IGRANT;
         end
         IGRANT, DGRANT: begin
            if (!own_req || done || abort)
               next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      bus.ramREN   = 1'b0;
      bus.ramWEN   = 1'b0;
      bus.ramaddr  = '0;
      bus.ramstore = '0;
      case (state)
         IGRANT: begin
            bus.ramREN  = 1'b1;
            bus.ramaddr = bus.iaddr;
         end
         DGRANT: begin
            bus.ramREN   = bus.dREN;
            bus.ramWEN   = bus.dWEN & ~bus.dREN;
            bus.ramaddr  = bus.daddr;
            bus.ramstore = bus.dstore;
         end
         default: ;
      endcase
      // an aborted access releases the requester for one cycle with zero data
      bus.iwait = bus.iREN & ~(granted_i & (done | abort));
      bus.dwait = d_req & ~(granted_d & (done | abort));
      bus.iload = (granted_i & done) ? bus.ramload : '0;
      bus.dload = (granted_d & done) ? bus.ramload : '0;
      bus.err   = err_r;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change on the falling edge and
// outputs are sampled 1 ns later, well clear of the rising edge.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   logic CLK = 1'b0;
   logic nRST;
   int   n_total = 0;
   int   n_bad   = 0;

   mem_arbiter_if bus ();

   mem_arbiter #(.MAX_RETRY(3)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge CLK);
   endtask

   initial begin
      int          grants;
      logic [31:0] seq [6];
      logic [31:0] want;

      nRST         = 1'b0;
      bus.halt     = 1'b0;
      bus.iREN     = 1'b0;
      bus.iaddr    = '0;
      bus.dREN     = 1'b0;
      bus.dWEN     = 1'b0;
      bus.daddr    = '0;
      bus.dstore   = '0;
      bus.ramload  = '0;
      bus.ramstate = FREE;

      #12;
      chk("rst_ramREN", {31'd0, bus.ramREN}, 32'd0);
      chk("rst_iwait",  {31'd0, bus.iwait},  32'd0);
      chk("rst_err",    {31'd0, bus.err},    32'd0);
      step(); nRST = 1'b1;

      // single fetch: BUSY, BUSY, ACCESS
      step(); bus.iREN = 1'b1; bus.iaddr = 32'h40; bus.ramstate = BUSY; #1;
      chk("if_idle_ramREN", {31'd0, bus.ramREN}, 32'd0);
      chk("if_idle_iwait",  {31'd0, bus.iwait},  32'd1);
      step(); #1;
      chk("if_c1_ramREN",  {31'd0, bus.ramREN}, 32'd1);
      chk("if_c1_ramaddr", bus.ramaddr, 32'h40);
      chk("if_c1_iwait",   {31'd0, bus.iwait}, 32'd1);
      step(); #1;
      chk("if_c2_iwait",   {31'd0, bus.iwait}, 32'd1);
      step(); bus.ramstate = ACCESS; bus.ramload = 32'h2108000A; #1;
      chk("if_acc_iwait", {31'd0, bus.iwait}, 32'd0);
      chk("if_acc_iload", bus.iload, 32'h2108000A);
      step(); bus.iREN = 1'b0; bus.ramstate = FREE; #1;
      chk("if_end_ramREN", {31'd0, bus.ramREN}, 32'd0);
      chk("if_end_iwait",  {31'd0, bus.iwait},  32'd0);

      // simultaneous write + fetch: data wins since last owner was INSTR
      step();
      bus.dWEN = 1'b1; bus.daddr = 32'h100; bus.dstore = 32'hDEADBEEF;
      bus.iREN = 1'b1; bus.iaddr = 32'h44; bus.ramstate = BUSY; #1;
      chk("both_idle_dwait", {31'd0, bus.dwait}, 32'd1);
      chk("both_idle_iwait", {31'd0, bus.iwait}, 32'd1);
      step(); #1;
      chk("dg_ramWEN",   {31'd0, bus.ramWEN}, 32'd1);
      chk("dg_ramREN",   {31'd0, bus.ramREN}, 32'd0);
      chk("dg_ramaddr",  bus.ramaddr,  32'h100);
      chk("dg_ramstore", bus.ramstore, 32'hDEADBEEF);
      step(); bus.ramstate = ACCESS; #1;
      chk("dg_acc_dwait", {31'd0, bus.dwait}, 32'd0);
      chk("dg_acc_iwait", {31'd0, bus.iwait}, 32'd1);
      step(); bus.dWEN = 1'b0; bus.ramstate = BUSY; #1;
      chk("mid_ramREN", {31'd0, bus.ramREN}, 32'd0);
      chk("mid_iwait",  {31'd0, bus.iwait},  32'd1);
      step(); bus.ramstate = ACCESS; bus.ramload = 32'h12345678; #1;
      chk("ig_ramaddr", bus.ramaddr, 32'h44);
      chk("ig_iwait",   {31'd0, bus.iwait}, 32'd0);
      chk("ig_iload",   bus.iload, 32'h12345678);
      step(); bus.iREN = 1'b0; bus.ramstate = FREE; #1;

      // alternation with both requests held; last owner INSTR so D first
      step();
      bus.dREN = 1'b1; bus.daddr = 32'h200; bus.iREN = 1'b1; bus.iaddr = 32'h300;
      bus.ramstate = ACCESS;
      grants = 0;
      for (int c = 0; c < 40 && grants < 6; c++) begin
         #1;
         if (bus.ramREN) begin
            seq[grants] = bus.ramaddr;
            grants++;
         end
         step();
      end
      chk("alt_count", grants, 32'd6);
      for (int k = 0; k < 6; k++) begin
         want = (k % 2 == 0) ? 32'h200 : 32'h300;
         if (k < grants) chk($sformatf("alt_%0d", k), seq[k], want);
      end
      bus.dREN = 1'b0; bus.iREN = 1'b0; bus.ramstate = FREE;
      step();

      // three ERRORs on a data read abort the access and set err
      step(); bus.dREN = 1'b1; bus.daddr = 32'h80; bus.ramstate = ERROR; bus.ramload = 32'h55; #1;
      chk("rt_idle_dwait", {31'd0, bus.dwait}, 32'd1);
      step(); #1;
      chk("rt_e1_dwait", {31'd0, bus.dwait}, 32'd1);
      chk("rt_e1_err",   {31'd0, bus.err},   32'd0);
      step(); #1;
      chk("rt_e2_dwait", {31'd0, bus.dwait}, 32'd1);
      chk("rt_e2_ramREN", {31'd0, bus.ramREN}, 32'd1);
      step(); #1;
      chk("rt_e3_dwait", {31'd0, bus.dwait}, 32'd0);
      chk("rt_e3_dload", bus.dload, 32'd0);
      step(); bus.ramstate = BUSY; #1;
      chk("rt_after_err",    {31'd0, bus.err},    32'd1);
      chk("rt_after_ramREN", {31'd0, bus.ramREN}, 32'd0);
      chk("rt_after_dwait",  {31'd0, bus.dwait},  32'd1);
      bus.dREN = 1'b0;
      step(); bus.ramstate = FREE;

      // halt blocks fetch grants but not data
      step(); bus.halt = 1'b1; bus.iREN = 1'b1; bus.iaddr = 32'h60; bus.ramstate = ACCESS;
      for (int c = 0; c < 10; c++) begin
         #1;
         chk($sformatf("halt_%0d_ramREN", c), {31'd0, bus.ramREN}, 32'd0);
         step();
      end
      bus.dREN = 1'b1; bus.daddr = 32'h90; bus.ramstate = BUSY; #1;
      chk("halt_d_idle_dwait", {31'd0, bus.dwait}, 32'd1);
      step(); #1;
      chk("halt_d_ramREN",  {31'd0, bus.ramREN}, 32'd1);
      chk("halt_d_ramaddr", bus.ramaddr, 32'h90);
      step(); bus.ramstate = ACCESS; bus.ramload = 32'hCAFE0001; #1;
      chk("halt_d_dwait", {31'd0, bus.dwait}, 32'd0);
      chk("halt_d_dload", bus.dload, 32'hCAFE0001);
      step(); bus.dREN = 1'b0; #1;
      chk("halt_after_ramREN", {31'd0, bus.ramREN}, 32'd0);
      step(); #1;
      chk("halt_after2_ramREN", {31'd0, bus.ramREN}, 32'd0);
      bus.halt = 1'b0; bus.iREN = 1'b0; bus.ramstate = FREE;
      step();

      // async reset in the middle of a data write
      step(); bus.dWEN = 1'b1; bus.daddr = 32'h120; bus.dstore = 32'h0BADF00D; bus.ramstate = BUSY; #1;
      step(); #1;
      chk("rs_pre_ramWEN", {31'd0, bus.ramWEN}, 32'd1);
      #2 nRST = 1'b0; #1;
      chk("rs_now_ramWEN", {31'd0, bus.ramWEN}, 32'd0);
      chk("rs_now_ramREN", {31'd0, bus.ramREN}, 32'd0);
      step(); bus.dWEN = 1'b0; bus.ramstate = FREE; nRST = 1'b1; #1;
      chk("rs_post_err",    {31'd0, bus.err},    32'd0);
      chk("rs_post_ramREN", {31'd0, bus.ramREN}, 32'd0);
      chk("rs_post_dwait",  {31'd0, bus.dwait},  32'd0);
      step(); #1;
      chk("rs_idle_ramWEN", {31'd0, bus.ramWEN}, 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
